fir_seq_ctrl: RTL and testbench

FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

---
 rtl/fir_ctrl_pkg.sv | 19 +
 rtl/fir_ctrl_ofifo.sv | 63 ++++++
 rtl/fir_seq_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_fir_seq_ctrl.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_ctrl_pkg.sv
// Shared types and default sizing for the FIR sequencing controller.
//   fir_state_t : controller FSM state encoding
//   DEF_*       : default parameter values for fir_seq_ctrl
package fir_ctrl_pkg;

    localparam int DEF_NTAPS = 8;
    localparam int DEF_IW    = 12;
    localparam int DEF_OW    = 2 * DEF_IW + 7;
    localparam int DEF_LENW  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_FLUSH,
        ST_DRAIN
    } fir_state_t;

endpackage

// File: rtl/fir_ctrl_ofifo.sv
// Result FIFO with valid/ready-style flags.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : synchronous flush (drops all entries)
//   push/push_data : write side; a push on full is accepted only with a pop
//   pop/pop_data   : read side; pop_data is the head entry, 0 when empty
//   full, empty, free_cnt : occupancy flags and free slot count
module fir_ctrl_ofifo #(
    parameter  int WIDTH = 31,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      free_cnt
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign free_cnt = (AW+1)'(DEPTH) - count;
    assign do_pop   = pop & ~empty;
    assign do_push  = push & ~clr & (~full | do_pop);
    // Head is masked while empty so the output reads 0 out of reset.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fir_seq_ctrl.sv
// Block sequencer for an external FIR datapath.
//   i_clk, i_reset_n          : clock, asynchronous active-low reset
//   i_cfg_tap_*               : shadow tap writes (IDLE only)
//   i_cfg_len, i_start        : block length and start pulse
//   i_abort                   : abandon current block
//   i_s_valid/i_s_data/o_s_ready : input sample stream
//   o_r_valid/o_r_data/i_r_ready : result stream from the output FIFO
//   o_busy, o_done, o_cfg_err : status
//   o_fir_*                   : FIR control (clear, enable, sample, tap load, taps)
//   i_fir_result/i_fir_valid  : FIR result, valid one cycle after o_fir_ce
module fir_seq_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int NTAPS  = DEF_NTAPS,
    parameter int IW     = DEF_IW,
    parameter int OW     = 2 * IW + 7,
    parameter int LENW   = DEF_LENW,
    parameter int ODEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_cfg_tap_we,
    input  logic [3:0]            i_cfg_tap_addr,
    input  logic [IW-1:0]         i_cfg_tap_data,
    input  logic [LENW-1:0]       i_cfg_len,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic                  i_s_valid,
    input  logic [IW-1:0]         i_s_data,
    output logic                  o_s_ready,
    output logic                  o_r_valid,
    output logic [OW-1:0]         o_r_data,
    input  logic                  i_r_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_cfg_err,
    output logic                  o_fir_clr,
    output logic                  o_fir_ce,
    output logic [IW-1:0]         o_fir_sample,
    output logic                  o_fir_tap_wr,
    output logic [(NTAPS+1)*IW-1:0] o_fir_taps,
    input  logic [OW-1:0]         i_fir_result,
    input  logic                  i_fir_valid
);

    localparam int FAW = $clog2(ODEPTH);

    fir_state_t    state_q, state_d;
    logic [IW-1:0] taps_q [NTAPS+1];
    logic [LENW-1:0] len_q;
    logic [LENW-1:0] smp_cnt_q;
    logic [LENW-1:0] fl_cnt_q;
    logic          inflight_q;
    logic          cfg_err_q;
    logic          abort_act;
    logic          space;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [FAW:0]  fifo_free;

    assign abort_act = i_abort && (state_q != ST_IDLE);
    // Two free slots: one for the result already in the FIR, one for this cycle's.
    assign space     = (fifo_free >= (FAW+1)'(2));
    assign o_busy    = (state_q != ST_IDLE);
    assign o_cfg_err = cfg_err_q;
    assign o_r_valid = ~fifo_empty;
    assign fifo_pop  = o_r_valid & i_r_ready;
    // Results are dropped outside a block and during an abort so that an
    // in-flight result never reappears after the flush.
    assign fifo_push = i_fir_valid && (state_q != ST_IDLE) && !abort_act
                       && (!fifo_full || fifo_pop);

    always_comb begin
        o_fir_taps = '0;
        for (int unsigned k = 0; k <= NTAPS; k++) begin
            o_fir_taps[k*IW +: IW] = taps_q[k];
        end
    end

    always_comb begin
        state_d      = state_q;
        o_s_ready    = 1'b0;
        o_fir_ce     = 1'b0;
        o_fir_sample = '0;
        o_fir_tap_wr = 1'b0;
        o_fir_clr    = 1'b0;
        o_done       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start && (i_cfg_len != '0)) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                o_fir_tap_wr = 1'b1;
                o_fir_clr    = 1'b1;
                state_d      = ST_RUN;
            end
            ST_RUN: begin
                o_s_ready    = space;
                o_fir_ce     = i_s_valid & space;
                o_fir_sample = i_s_data;
                if (o_fir_ce && (smp_cnt_q == len_q - 1'b1)) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                o_fir_ce = space;
                if (space && (fl_cnt_q == LENW'(NTAPS - 1))) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_empty && !inflight_q) begin
                    o_done  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort_act) begin
            state_d      = ST_IDLE;
            o_s_ready    = 1'b0;
            o_fir_ce     = 1'b0;
            o_fir_tap_wr = 1'b0;
            o_fir_clr    = 1'b1;
            o_done       = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            smp_cnt_q  <= '0;
            fl_cnt_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= o_fir_ce;
            case (state_q)
                ST_IDLE: begin
                    smp_cnt_q <= '0;
                    fl_cnt_q  <= '0;
                    if (i_start && (i_cfg_len != '0)) len_q <= i_cfg_len;
                end
                ST_RUN:   if (o_fir_ce) smp_cnt_q <= smp_cnt_q + 1'b1;
                ST_FLUSH: if (o_fir_ce) fl_cnt_q <= fl_cnt_q + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cfg_err_q <= 1'b0;
            for (int unsigned k = 0; k <= NTAPS; k++) taps_q[k] <= '0;
        end else begin
            cfg_err_q <= 1'b0;
            if (i_cfg_tap_we) begin
                if ((state_q == ST_IDLE) && (32'(i_cfg_tap_addr) <= 32'(NTAPS))) begin
                    for (int unsigned k = 0; k <= NTAPS; k++) begin
                        if (i_cfg_tap_addr == 4'(k)) taps_q[k] <= i_cfg_tap_data;
                    end
                end else begin
                    cfg_err_q <= 1'b1;
                end
            end
        end
    end

    fir_ctrl_ofifo #(
        .WIDTH (OW),
        .DEPTH (ODEPTH)
    ) u_ofifo (
        .clk       (i_clk),
        .rst_n     (i_reset_n),
        .clr       (abort_act),
        .push      (fifo_push),
        .push_data (i_fir_result),
        .pop       (fifo_pop),
        .pop_data  (o_r_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .free_cnt  (fifo_free)
    );

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl with a one-cycle-latency FIR model.
module tb_fir_seq_ctrl;

    localparam int NT = 8;
    localparam int IW = 12;
    localparam int OW = 2 * IW + 7;
    localparam int LW = 16;
    localparam int OD = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   i_cfg_tap_we;
    logic [3:0]             i_cfg_tap_addr;
    logic [IW-1:0]          i_cfg_tap_data;
    logic [LW-1:0]          i_cfg_len;
    logic                   i_start;
    logic                   i_abort;
    logic                   i_s_valid;
    logic [IW-1:0]          i_s_data;
    logic                   o_s_ready;
    logic                   o_r_valid;
    logic [OW-1:0]          o_r_data;
    logic                   i_r_ready;
    logic                   o_busy;
    logic                   o_done;
    logic                   o_cfg_err;
    logic                   o_fir_clr;
    logic                   o_fir_ce;
    logic [IW-1:0]          o_fir_sample;
    logic                   o_fir_tap_wr;
    logic [(NT+1)*IW-1:0]   o_fir_taps;
    logic [OW-1:0]          fir_result;
    logic                   fir_valid;

    int checks = 0;
    int errors = 0;
    int res_q[$];
    int done_cnt = 0;
    bit sready_low_seen = 0;
    int stab_err = 0;
    bit stall_prev = 0;
    logic [OW-1:0] stall_data;
    bit bp_mode = 0;
    int cyc = 0;
    int exp_imp[17];
    logic [IW-1:0] imp_s[9];
    logic [(NT+1)*IW-1:0] exp_taps;

    always #5 clk = ~clk;

    fir_seq_ctrl #(
        .NTAPS (NT),
        .IW    (IW),
        .OW    (OW),
        .LENW  (LW),
        .ODEPTH(OD)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_cfg_tap_we  (i_cfg_tap_we),
        .i_cfg_tap_addr(i_cfg_tap_addr),
        .i_cfg_tap_data(i_cfg_tap_data),
        .i_cfg_len     (i_cfg_len),
        .i_start       (i_start),
        .i_abort       (i_abort),
        .i_s_valid     (i_s_valid),
        .i_s_data      (i_s_data),
        .o_s_ready     (o_s_ready),
        .o_r_valid     (o_r_valid),
        .o_r_data      (o_r_data),
        .i_r_ready     (i_r_ready),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_cfg_err     (o_cfg_err),
        .o_fir_clr     (o_fir_clr),
        .o_fir_ce      (o_fir_ce),
        .o_fir_sample  (o_fir_sample),
        .o_fir_tap_wr  (o_fir_tap_wr),
        .o_fir_taps    (o_fir_taps),
        .i_fir_result  (fir_result),
        .i_fir_valid   (fir_valid)
    );

    // One-cycle FIR model: coefficients latched on tap load, result of the
    // sample presented with o_fir_ce appears on the next cycle.
    logic signed [IW-1:0] coef [NT+1];
    logic signed [IW-1:0] dl [NT];

    function automatic int fir_sum(input logic signed [IW-1:0] x);
        int acc;
        acc = int'(coef[0]) * int'(x);
        for (int k = 1; k <= NT; k++) acc += int'(coef[k]) * int'(dl[k-1]);
        return acc;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fir_valid  <= 1'b0;
            fir_result <= '0;
            for (int k = 0; k <= NT; k++) coef[k] <= '0;
            for (int k = 0; k < NT; k++) dl[k] <= '0;
        end else begin
            if (o_fir_tap_wr) begin
                for (int k = 0; k <= NT; k++) coef[k] <= o_fir_taps[k*IW +: IW];
            end
            if (o_fir_clr) begin
                fir_valid <= 1'b0;
                for (int k = 0; k < NT; k++) dl[k] <= '0;
            end else begin
                fir_valid <= o_fir_ce;
                if (o_fir_ce) begin
                    fir_result <= OW'(fir_sum(o_fir_sample));
                    dl[0] <= o_fir_sample;
                    for (int k = 1; k < NT; k++) dl[k] <= dl[k-1];
                end
            end
        end
    end

    // Observation at the falling edge: popped results, done pulses,
    // input stalls, and result stability while the consumer stalls.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_r_valid && i_r_ready) res_q.push_back(int'($signed(o_r_data)));
            if (o_done) done_cnt++;
            if (o_busy && i_s_valid && !o_s_ready) sready_low_seen = 1;
            if (stall_prev && o_r_valid && (o_r_data !== stall_data)) stab_err++;
            stall_prev = o_r_valid && !i_r_ready;
            stall_data = o_r_data;
        end else begin
            stall_prev = 0;
        end
    end

    initial begin
        i_r_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            i_r_ready = bp_mode ? ((cyc % 4) == 0) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no end, required finish");
        $fatal(1, "watchdog");
    end

    task automatic write_taps();
        for (int k = 0; k <= NT; k++) begin
            i_cfg_tap_we   = 1'b1;
            i_cfg_tap_addr = 4'(k);
            i_cfg_tap_data = IW'(k + 1);
            @(posedge clk);
            #1;
        end
        i_cfg_tap_we = 1'b0;
    endtask

    task automatic start_block(input logic [LW-1:0] len);
        i_cfg_len = len;
        i_start   = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic feed_impulse(output bit to);
        int idx = 0;
        bit hs;
        to = 1;
        i_s_valid = 1'b1;
        for (int g = 0; g < 2000; g++) begin
            i_s_data = imp_s[idx];
            @(negedge clk);
            hs = o_s_ready;
            @(posedge clk);
            #1;
            if (hs) idx++;
            if (idx == 9) begin
                to = 0;
                break;
            end
        end
        i_s_valid = 1'b0;
        i_s_data  = '0;
    endtask

    task automatic wait_done(input int d0, output bit to);
        to = 1;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            #1;
            if (done_cnt != d0) begin
                to = 0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({o_s_ready, o_r_valid, o_busy, o_done, o_cfg_err, o_fir_ce, o_fir_tap_wr, o_fir_clr} !== 8'b0)
            begin errors++; $display("FAIL reset_flags: got %b required 00000000",
                {o_s_ready, o_r_valid, o_busy, o_done, o_cfg_err, o_fir_ce, o_fir_tap_wr, o_fir_clr}); end
        checks++;
        if (o_fir_sample !== '0 || o_r_data !== '0 || o_fir_taps !== '0)
            begin errors++; $display("FAIL reset_data: got sample=%0h rdata=%0h taps=%0h required 0",
                o_fir_sample, o_r_data, o_fir_taps); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_impulse(input string tag);
        int d0;
        bit to;
        res_q.delete();
        d0 = done_cnt;
        start_block(16'd9);
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b1 || o_fir_tap_wr !== 1'b1 || o_fir_clr !== 1'b1)
            begin errors++; $display("FAIL %s_load: got busy/tap_wr/clr=%b%b%b required 111",
                tag, o_busy, o_fir_tap_wr, o_fir_clr); end
        @(posedge clk);
        #1;
        feed_impulse(to);
        checks++;
        if (to) begin errors++; $display("FAIL %s_feed: got timeout required 9 handshakes", tag); end
        wait_done(d0, to);
        checks++;
        if (to) begin errors++; $display("FAIL %s_done_wait: got timeout required o_done", tag); end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (done_cnt - d0 != 1)
            begin errors++; $display("FAIL %s_done_count: got %0d required 1", tag, done_cnt - d0); end
        checks++;
        if (res_q.size() != 17)
            begin errors++; $display("FAIL %s_result_count: got %0d required 17", tag, res_q.size()); end
        for (int i = 0; i < 17 && i < res_q.size(); i++) begin
            checks++;
            if (res_q[i] != exp_imp[i])
                begin errors++; $display("FAIL %s_result[%0d]: got %0d required %0d",
                    tag, i, res_q[i], exp_imp[i]); end
        end
        checks++;
        if (o_busy !== 1'b0)
            begin errors++; $display("FAIL %s_idle_after: got busy=%b required 0", tag, o_busy); end
    endtask

    task automatic test_backpressure();
        sready_low_seen = 0;
        stab_err = 0;
        bp_mode = 1;
        test_impulse("bp");
        bp_mode = 0;
        checks++;
        if (!sready_low_seen)
            begin errors++; $display("FAIL bp_sready_drop: got no stall required o_s_ready low while full"); end
        checks++;
        if (stab_err != 0)
            begin errors++; $display("FAIL bp_stability: got %0d data changes while stalled required 0", stab_err); end
    endtask

    task automatic test_len0();
        int d0 = done_cnt;
        int busy_seen = 0;
        start_block(16'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (o_busy) busy_seen++;
        end
        checks++;
        if (busy_seen != 0)
            begin errors++; $display("FAIL len0_busy: got %0d busy cycles required 0", busy_seen); end
        checks++;
        if (done_cnt != d0)
            begin errors++; $display("FAIL len0_done: got %0d pulses required 0", done_cnt - d0); end
    endtask

    task automatic test_cfg_err();
        int d0;
        bit to;
        i_cfg_tap_we = 1'b1; i_cfg_tap_addr = 4'd9; i_cfg_tap_data = 12'd77;
        @(posedge clk);
        #1;
        i_cfg_tap_we = 1'b0;
        checks++;
        if (o_cfg_err !== 1'b1)
            begin errors++; $display("FAIL cfg_bad_addr: got %b required 1", o_cfg_err); end
        @(posedge clk);
        #1;
        checks++;
        if (o_cfg_err !== 1'b0)
            begin errors++; $display("FAIL cfg_pulse_width: got %b required 0", o_cfg_err); end
        checks++;
        if (o_fir_taps !== exp_taps)
            begin errors++; $display("FAIL cfg_taps_idle: got %0h required %0h", o_fir_taps, exp_taps); end
        d0 = done_cnt;
        start_block(16'd9);
        @(posedge clk);
        #1;
        i_cfg_tap_we = 1'b1; i_cfg_tap_addr = 4'd0; i_cfg_tap_data = 12'd100;
        @(posedge clk);
        #1;
        i_cfg_tap_we = 1'b0;
        checks++;
        if (o_cfg_err !== 1'b1)
            begin errors++; $display("FAIL cfg_run_write: got %b required 1", o_cfg_err); end
        checks++;
        if (o_fir_taps !== exp_taps)
            begin errors++; $display("FAIL cfg_taps_run: got %0h required %0h", o_fir_taps, exp_taps); end
        feed_impulse(to);
        wait_done(d0, to);
        checks++;
        if (to) begin errors++; $display("FAIL cfg_block_done: got timeout required o_done"); end
    endtask

    task automatic test_abort();
        int d0;
        int rv_seen = 0;
        bit to;
        d0 = done_cnt;
        start_block(16'd9);
        @(posedge clk);
        #1;
        feed_impulse(to);
        i_abort = 1'b1;
        @(negedge clk);
        checks++;
        if (o_fir_clr !== 1'b1 || o_fir_ce !== 1'b0)
            begin errors++; $display("FAIL abort_clr: got clr/ce=%b%b required 10", o_fir_clr, o_fir_ce); end
        @(posedge clk);
        #1;
        i_abort = 1'b0;
        checks++;
        if (o_busy !== 1'b0 || o_r_valid !== 1'b0)
            begin errors++; $display("FAIL abort_idle: got busy/r_valid=%b%b required 00", o_busy, o_r_valid); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (o_r_valid) rv_seen++;
        end
        checks++;
        if (rv_seen != 0)
            begin errors++; $display("FAIL abort_no_results: got %0d valid cycles required 0", rv_seen); end
        checks++;
        if (done_cnt != d0)
            begin errors++; $display("FAIL abort_no_done: got %0d pulses required 0", done_cnt - d0); end
        @(posedge clk);
        #1;
        test_impulse("after_abort");
    endtask

    task automatic test_reset_mid_block();
        int d0 = done_cnt;
        start_block(16'd9);
        @(posedge clk);
        #1;
        i_s_valid = 1'b1; i_s_data = 12'd1;
        @(posedge clk);
        #1;
        i_s_data = 12'd5;
        @(negedge clk);
        checks++;
        if (o_fir_ce !== 1'b1 || o_fir_sample !== 12'd5)
            begin errors++; $display("FAIL rstmid_run: got ce=%b sample=%0d required 1 5", o_fir_ce, o_fir_sample); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_s_ready, o_r_valid, o_busy, o_done, o_cfg_err, o_fir_ce, o_fir_tap_wr, o_fir_clr} !== 8'b0)
            begin errors++; $display("FAIL rstmid_flags: got %b required 00000000",
                {o_s_ready, o_r_valid, o_busy, o_done, o_cfg_err, o_fir_ce, o_fir_tap_wr, o_fir_clr}); end
        checks++;
        if (o_fir_sample !== '0 || o_r_data !== '0 || o_fir_taps !== '0)
            begin errors++; $display("FAIL rstmid_data: got sample=%0h rdata=%0h taps=%0h required 0",
                o_fir_sample, o_r_data, o_fir_taps); end
        i_s_valid = 1'b0;
        i_s_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != d0)
            begin errors++; $display("FAIL rstmid_no_done: got %0d pulses required 0", done_cnt - d0); end
        write_taps();
        test_impulse("after_reset");
    endtask

    initial begin
        exp_imp = '{1, 2, 3, 4, 5, 6, 7, 8, 11, 4, 6, 8, 10, 12, 14, 16, 18};
        imp_s   = '{12'd1, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd2};
        for (int k = 0; k <= NT; k++) exp_taps[k*IW +: IW] = IW'(k + 1);
        i_cfg_tap_we   = 1'b0;
        i_cfg_tap_addr = '0;
        i_cfg_tap_data = '0;
        i_cfg_len      = '0;
        i_start        = 1'b0;
        i_abort        = 1'b0;
        i_s_valid      = 1'b0;
        i_s_data       = '0;

        test_reset();
        write_taps();
        test_impulse("impulse");
        test_backpressure();
        test_len0();
        test_cfg_err();
        test_abort();
        test_reset_mid_block();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
